melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
Programmable note sequencer for the audio/buzzer path. It plays a table of (note code, duration) entries at a fixed tick rate and presents the current note code to the downstream tone generator, where code 0 means silence. It generalises the fixed single-tune player with the following:
- a writable song table and parametrised widths/depth;
- start/stop/pause control;
- loop mode;
- a done pulse.

Parameters:
- TICK_DIV, 1666666, clk cycles per duration tick (60 Hz at 100 MHz); must be >= 2.
- NOTE_W, 4, note code width; code 0 means rest/silence.
- DUR_W, 8, duration field width, in ticks.
- DEPTH, 16, song table entries.
- ADDR_W, $clog2(DEPTH), table index width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: play from entry 0
- stop  in  1  one-cycle pulse: abort playback
- pause  in  1  level: freeze playback and silence output while high
- loop_en  in  1  level: wrap to entry 0 after the last entry instead of finishing
- song_len  in  ADDR_W+1  number of valid entries, 0..DEPTH; sampled on start
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  table write address
- wr_note  in  NOTE_W  note code to write
- wr_dur  in  DUR_W  duration (ticks) to write
- note  out  NOTE_W  current note code; 0 when idle or paused
- busy  out  1  high in PLAY or PAUSE
- idx  out  ADDR_W  index of the entry currently playing
- done  out  1  one-cycle pulse when a non-looping song ends

Behaviour:
- Reset (synchronous, active-high) sets:
  - outputs: note=0, busy=0, idx=0, done=0;
  - internal: state=IDLE, prescaler=0, tick counter=0, latched length=0.
- The table is not reset. Table reads are asynchronous (distributed RAM).
- Writes are accepted in any state, one per cycle.
- A note is latched from the table when its entry is entered. Rewriting the playing entry takes effect only on its next visit.
- Prescaler:
  - counts 0..TICK_DIV-1 while in PLAY;
  - tick = (prescaler==TICK_DIV-1);
  - held in PAUSE;
  - cleared whenever an entry is entered.
- Effective duration is max(dur,1) ticks, so dur=0 plays for 1 tick.
- Each entry drives note for exactly max(dur,1)*TICK_DIV PLAY cycles, with no gap cycle between entries.
- States:
  - IDLE: when start and !stop and song_len!=0, latch song_len, set idx=0, load note/dur from entry 0, and go to PLAY. note is valid the cycle after start is sampled. start with song_len==0 is ignored.
  - PLAY: on a tick whose tick count equals max(dur,1)-1, advance:
    - if idx != len-1: idx+1, load the next entry;
    - else if loop_en: idx=0, load entry 0;
    - else go to IDLE with note=0, busy=0, and done=1 for one cycle.
  - PLAY -> PAUSE when pause=1; note reads 0, and the prescaler and tick counter are held.
  - PAUSE: when pause=0, return to PLAY with the latched note restored. The remaining duration is preserved, so paused cycles are excluded from the note length.
- Priority within any cycle: rst > stop > start > pause > tick.
  - stop in PLAY or PAUSE: IDLE next cycle, note=0, no done pulse.
  - start in PLAY or PAUSE restarts from entry 0 using a freshly sampled song_len.
  - start and stop in the same cycle: stop wins.
- loop_en is sampled at the last-entry boundary only. song_len changes during playback are ignored.
- idx, note, busy and done are all registered outputs.

Decomposition:
- Package melody_pkg holds:
  - typedef state_t {IDLE, PLAY, PAUSE};
  - typedef struct entry_t {note, dur};
  - localparam REST = '0.
- One natural sub-module, tick_prescaler (parameter TICK_DIV; ports clk, rst, en, clr, tick), reused by other timed blocks.
- Table storage and FSM stay in melody_sequencer.

Test Plan:
All scenarios run with TICK_DIV=4 and table {0:(7,2), 1:(2,1), 2:(10,3)}.
1. song_len=3, loop_en=0, start -> note=7 for 8 cycles, 2 for 4, 10 for 12; then note=0, busy=0, and done=1 for exactly one cycle; idx steps 0,1,2.
2. loop_en=1, start -> after 10's 12 cycles, note=7 the next cycle (no gap, no done); stop mid-note -> next cycle note=0, busy=0, done=0.
3. pause held 5 cycles after note 2's first cycle -> note=0 for those 5 cycles; note 2 then resumes for 3 more cycles (4 total), and note 10 follows.
4. Write entry 1 = (5,0) before start -> note 5 lasts exactly 4 cycles. Write entry 0 = (9,1) while entry 0 plays -> 7 continues; the loop's next visit shows 9.
5. start with song_len=0 -> busy stays 0, no done. start and stop in the same cycle from IDLE -> stays IDLE, note=0.
6. rst asserted mid-note 10 -> next cycle note=0, busy=0, idx=0, done=0; a subsequent start replays from 7.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer and its users.
package melody_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        PLAY  = ST_PLAY,
        PAUSE = ST_PAUSE
    } state_t;

    localparam int unsigned PKG_NOTE_W = 4;
    localparam int unsigned PKG_DUR_W  = 8;

    typedef struct packed {
        logic [PKG_NOTE_W-1:0] note;
        logic [PKG_DUR_W-1:0]  dur;
    } entry_t;

    // Note code meaning silence.
    localparam int unsigned REST = 0;

endpackage

// File: rtl/melody_sequencer_if.sv
// Control, table-write and status bundle of the melody sequencer.
interface melody_sequencer_if #(
    parameter int unsigned NOTE_W = 4,
    parameter int unsigned DUR_W  = 8,
    parameter int unsigned ADDR_W = 4
);

    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W:0]   song_len;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [NOTE_W-1:0] wr_note;
    logic [DUR_W-1:0]  wr_dur;
    logic [NOTE_W-1:0] note;
    logic              busy;
    logic [ADDR_W-1:0] idx;
    logic              done;

    modport master (
        output start, stop, pause, loop_en, song_len,
        output wr_en, wr_addr, wr_note, wr_dur,
        input  note, busy, idx, done
    );

    modport slave (
        input  start, stop, pause, loop_en, song_len,
        input  wr_en, wr_addr, wr_note, wr_dur,
        output note, busy, idx, done
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running cycle divider: tick is high on the last cycle of each period.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1666666
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: clear wins over enable, wrap at the end of the period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Programmable note sequencer: plays (note, duration) table entries at a
// fixed tick rate with start/stop/pause, loop mode and a done pulse.
module melody_sequencer #(
    parameter int unsigned TICK_DIV = 1666666,
    parameter int unsigned NOTE_W   = 4,
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    melody_sequencer_if.slave  bus
);

    import melody_pkg::*;

    logic [NOTE_W-1:0] tbl_note [DEPTH];
    logic [DUR_W-1:0]  tbl_dur  [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;
    logic [DUR_W-1:0]  cur_dur_q, cur_dur_d;
    logic [DUR_W-1:0]  tcnt_q, tcnt_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic              presc_en;
    logic              tick;
    logic [DUR_W-1:0]  last_dur;
    logic              at_end;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (load),
        .tick (tick)
    );

    // Song table: one write per cycle in any state, never reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            tbl_note[bus.wr_addr] <= bus.wr_note;
            tbl_dur[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    assign last_dur = (cur_dur_q == '0) ? '0 : cur_dur_q - DUR_W'(1);
    assign at_end   = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));

    // Sequencer next state with priority stop > start > pause > tick.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cur_note_d = cur_note_q;
        cur_dur_d  = cur_dur_q;
        tcnt_d     = tcnt_q;
        note_d     = note_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        load_addr  = '0;
        presc_en   = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            note_d  = NOTE_W'(REST);
            busy_d  = 1'b0;
        end else if (bus.start && (bus.song_len != '0)) begin
            state_d   = PLAY;
            len_d     = bus.song_len;
            idx_d     = '0;
            busy_d    = 1'b1;
            load      = 1'b1;
            load_addr = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    // The cycle pause is sampled still showed the note, so it
                    // counts; only a coinciding tick is deferred past the pause.
                    presc_en = !(bus.pause && tick);
                    if (bus.pause) begin
                        state_d = PAUSE;
                        note_d  = NOTE_W'(REST);
                    end else if (tick) begin
                        if (tcnt_q == last_dur) begin
                            if (!at_end) begin
                                idx_d     = idx_q + ADDR_W'(1);
                                load      = 1'b1;
                                load_addr = idx_q + ADDR_W'(1);
                            end else if (bus.loop_en) begin
                                idx_d     = '0;
                                load      = 1'b1;
                                load_addr = '0;
                            end else begin
                                state_d = IDLE;
                                note_d  = NOTE_W'(REST);
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            tcnt_d = tcnt_q + DUR_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        state_d = PLAY;
                        note_d  = cur_note_q;
                    end
                end
                default: ;
            endcase
        end

        if (load) begin
            cur_note_d = tbl_note[load_addr];
            cur_dur_d  = tbl_dur[load_addr];
            note_d     = tbl_note[load_addr];
            tcnt_d     = '0;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cur_note_q <= '0;
            cur_dur_q  <= '0;
            tcnt_q     <= '0;
            note_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cur_note_q <= cur_note_d;
            cur_dur_q  <= cur_dur_d;
            tcnt_q     <= tcnt_d;
            note_q     <= note_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.note = note_q;
    assign bus.busy = busy_q;
    assign bus.idx  = idx_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with TICK_DIV=4.
module tb_melody_sequencer;

    localparam int unsigned TD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    melody_sequencer_if #(.NOTE_W(4), .DUR_W(8), .ADDR_W(4)) bus ();

    melody_sequencer #(
        .TICK_DIV (TD),
        .NOTE_W   (4),
        .DUR_W    (8),
        .DEPTH    (16),
        .ADDR_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    note;
        bit    busy;
        bit    chk_idx;
        int    idx;
        bit    done;
        int    n;
    } seg_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check every cycle of a segment of constant expected outputs.
    task automatic run_seg(input seg_t s);
        for (int i = 0; i < s.n; i++) begin
            chk({s.name, ".note"}, 32'(bus.note), s.note);
            chk({s.name, ".busy"}, 32'(bus.busy), 32'(s.busy));
            chk({s.name, ".done"}, 32'(bus.done), 32'(s.done));
            if (s.chk_idx) chk({s.name, ".idx"}, 32'(bus.idx), s.idx);
            step();
        end
    endtask

    task automatic seg(input string name, input int note, input bit busy,
                       input int idx, input bit done, input int n);
        seg_t s;
        s.name    = name;
        s.note    = note;
        s.busy    = busy;
        s.chk_idx = (idx >= 0);
        s.idx     = idx;
        s.done    = done;
        s.n       = n;
        run_seg(s);
    endtask

    task automatic wr(input int a, input int n, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_note = 4'(n);
        bus.wr_dur  = 8'(d);
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start(input int len, input bit lp);
        bus.song_len = 5'(len);
        bus.loop_en  = lp;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    seg_t t1 [5];

    initial begin
        int exp_note [$];
        int exp_idx  [$];
        int len, n, d, reps;

        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop_en = 0;
        bus.song_len = '0; bus.wr_en = 0; bus.wr_addr = '0;
        bus.wr_note = '0; bus.wr_dur = '0;
        rst = 1'b1;
        step();
        step();
        seg("reset", 0, 0, 0, 0, 1);
        rst = 1'b0;

        wr(0, 7, 2);
        wr(1, 2, 1);
        wr(2, 10, 3);

        // 1: plain playback, table-driven expected segments
        t1[0] = '{"t1_n7",   7,  1'b1, 1'b1, 0, 1'b0, 8};
        t1[1] = '{"t1_n2",   2,  1'b1, 1'b1, 1, 1'b0, 4};
        t1[2] = '{"t1_n10",  10, 1'b1, 1'b1, 2, 1'b0, 12};
        t1[3] = '{"t1_done", 0,  1'b0, 1'b0, 0, 1'b1, 1};
        t1[4] = '{"t1_idle", 0,  1'b0, 1'b0, 0, 1'b0, 3};
        do_start(3, 0);
        for (int i = 0; i < 5; i++) run_seg(t1[i]);

        // 2: loop wraps without gap or done; stop mid-note
        do_start(3, 1);
        seg("t2_n7",  7,  1, 0, 0, 8);
        seg("t2_n2",  2,  1, 1, 0, 4);
        seg("t2_n10", 10, 1, 2, 0, 12);
        seg("t2_wrap", 7, 1, 0, 0, 3);
        do_stop();
        seg("t2_stop", 0, 0, -1, 0, 3);
        bus.loop_en = 0;

        // 3: pause during note 2's first cycle for 5 cycles
        do_start(3, 0);
        seg("t3_n7", 7, 1, 0, 0, 8);
        chk("t3_n2first.note", 32'(bus.note), 2);
        chk("t3_n2first.idx", 32'(bus.idx), 1);
        bus.pause = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_paused.note", 32'(bus.note), 0);
            chk("t3_paused.busy", 32'(bus.busy), 1);
            chk("t3_paused.done", 32'(bus.done), 0);
            if (i == 4) bus.pause = 1'b0;
            step();
        end
        seg("t3_n2rest", 2,  1, 1, 0, 3);
        seg("t3_n10",    10, 1, 2, 0, 12);
        seg("t3_done",   0,  0, -1, 1, 1);
        seg("t3_idle",   0,  0, -1, 0, 2);

        // 4: dur=0 plays one tick; rewrite of playing entry deferred
        wr(1, 5, 0);
        do_start(3, 1);
        seg("t4_n7a", 7, 1, 0, 0, 3);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_note = 4'd9; bus.wr_dur = 8'd1;
        seg("t4_n7w", 7, 1, 0, 0, 1);
        bus.wr_en = 1'b0;
        seg("t4_n7b", 7,  1, 0, 0, 4);
        seg("t4_n5",  5,  1, 1, 0, 4);
        seg("t4_n10", 10, 1, 2, 0, 12);
        seg("t4_n9",  9,  1, 0, 0, 4);
        seg("t4_n5b", 5,  1, 1, 0, 4);
        do_stop();
        bus.loop_en = 0;
        seg("t4_stop", 0, 0, -1, 0, 1);
        wr(0, 7, 2);
        wr(1, 2, 1);

        // 5: start with zero length ignored; start+stop from IDLE
        do_start(0, 0);
        seg("t5_len0", 0, 0, -1, 0, 4);
        bus.song_len = 5'd3;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        seg("t5_startstop", 0, 0, -1, 0, 4);

        // 6: reset mid-note 10, then replay
        do_start(3, 0);
        seg("t6_n7",  7,  1, 0, 0, 8);
        seg("t6_n2",  2,  1, 1, 0, 4);
        seg("t6_n10", 10, 1, 2, 0, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        seg("t6_rst", 0, 0, 0, 0, 3);
        do_start(3, 0);
        seg("t6_re7", 7, 1, 0, 0, 8);
        seg("t6_re2", 2, 1, 1, 0, 1);
        do_stop();
        seg("t6_stop", 0, 0, -1, 0, 1);

        // Random songs against an expanded note-per-cycle model
        for (int it = 0; it < 20; it++) begin
            exp_note.delete();
            exp_idx.delete();
            len = $urandom_range(1, 6);
            for (int e = 0; e < len; e++) begin
                n = $urandom_range(0, 15);
                d = $urandom_range(0, 3);
                wr(e, n, d);
                reps = ((d == 0) ? 1 : d) * TD;
                for (int k = 0; k < reps; k++) begin
                    exp_note.push_back(n);
                    exp_idx.push_back(e);
                end
            end
            do_start(len, 0);
            foreach (exp_note[k]) begin
                chk("rnd.note", 32'(bus.note), exp_note[k]);
                chk("rnd.idx",  32'(bus.idx),  exp_idx[k]);
                chk("rnd.busy", 32'(bus.busy), 1);
                chk("rnd.done", 32'(bus.done), 0);
                step();
            end
            seg("rnd_done", 0, 0, -1, 1, 1);
            seg("rnd_idle", 0, 0, -1, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
